// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding architectural HI/LO.
// Shift-add multiply and restoring divide, one bit per cycle, sign-fixed at the end.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   rs_q;     // raw dividend, returned as HI on divide-by-zero
  logic [WIDTH-1:0]   md_q;     // |multiplicand| or |divisor|
  logic [WIDTH-1:0]   mq_q;     // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [CW-1:0]      cnt;
  logic               sign_a, sign_b, div_zero;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               st_signed, st_sa, st_sb;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign st_signed = ~i_op[0];
  assign st_sa     = st_signed & i_rs[WIDTH-1];
  assign st_sb     = st_signed & i_rt[WIDTH-1];

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mq_q[0] ? {1'b0, md_q} : '0);
  assign div_sh   = {rem[WIDTH-1:0], mq_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, md_q};

  assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_fix  = (sign_a ^ sign_b) ? -mq_q : mq_q;
  assign rem_fix  = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start) state_nx = CALC;
      CALC:    if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q     <= '0;
      rs_q     <= '0;
      md_q     <= '0;
      mq_q     <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            op_q     <= i_op;
            rs_q     <= i_rs;
            mq_q     <= st_sa ? -i_rs : i_rs;
            md_q     <= st_sb ? -i_rt : i_rt;
            sign_a   <= st_sa;
            sign_b   <= st_sb;
            div_zero <= (i_rt == '0);
            acc      <= '0;
            rem      <= '0;
            cnt      <= '0;
          end else begin
            if (i_mthi) hi_q <= i_wdata;
            if (i_mtlo) lo_q <= i_wdata;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[1]) begin
            // restoring step: keep the trial difference only when it did not borrow
            rem  <= div_diff[WIDTH] ? div_sh : div_diff;
            mq_q <= {mq_q[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc  <= {mul_sum, acc[WIDTH-1:1]};
            mq_q <= mq_q >> 1;
          end
        end
        FIX: begin
          done_q <= 1'b1;
          if (!op_q[1]) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi_q <= rs_q;
            lo_q <= {WIDTH{1'b1}};
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hi   = hi_q;
  assign o_lo   = lo_q;
  assign o_busy = (state != IDLE);
  assign o_done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, sign rules, div-by-zero, MT writes, async reset.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs = '0, rt = '0, wdata = '0;
  logic         mthi = 1'b0, mtlo = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  int errs = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_rs(rs), .i_rt(rt),
    .i_mthi(mthi), .i_mtlo(mtlo), .i_wdata(wdata),
    .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one op; optionally pair a dropped MTLO with the start, or poke a
  // second start + MTHI mid-CALC. Checks busy length, done pulse and HI/LO hold.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit mt_same, input bit poke);
    int bc, dc;
    logic [W-1:0] hi0, lo0;
    @(negedge clk);
    hi0 = hi; lo0 = lo;
    start = 1'b1; op = o; rs = a; rt = b;
    if (mt_same) begin mtlo = 1'b1; wdata = 32'h5555_5555; end
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    bc = 0; dc = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) bc++;
      if (done) dc++;
      if (k == 0 && mt_same) chk({tag, "_mtlo_drop"}, {32'h0, lo}, {32'h0, lo0});
      if (k == 5 && poke) begin
        start = 1'b1; op = 2'b01; rs = 32'h3; rt = 32'h3;
        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (k == 6 && poke) begin start = 1'b0; mthi = 1'b0; end
      if (k == 10) chk({tag, "_hold"}, {hi, lo}, {hi0, lo0});
      @(posedge clk); #1;
    end
    chk({tag, "_busy"}, 64'(bc), 64'd33);
    chk({tag, "_done"}, 64'(dc), 64'd1);
  endtask

  initial begin
    #12;
    chk("rst_state", {hi, lo}, 64'h0);
    chk("rst_flags", {62'h0, busy, done}, 64'h0);
    @(negedge clk); rst = 1'b0;

    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    chk("mult_min", {hi, lo}, 64'h4000_0000_0000_0000);
    do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("div_negdiv", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    chk("div_negdiv", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    do_op("divu", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    chk("divu", {hi, lo}, 64'h0000_0002_0000_000E);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op("divu_zero", 2'b11, 32'h1234, 32'h0, 1'b0, 1'b0);
    chk("divu_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    do_op("poke", 2'b11, 32'd100, 32'd7, 1'b0, 1'b1);
    chk("poke", {hi, lo}, 64'h0000_0002_0000_000E);

    // MTHI+MTLO together in IDLE
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both", {hi, lo}, 64'hA5A5_A5A5_A5A5_A5A5);

    do_op("start_mtlo", 2'b01, 32'd2, 32'd3, 1'b1, 1'b0);
    chk("start_mtlo", {hi, lo}, 64'h0000_0000_0000_0006);

    // async reset 10 cycles into CALC
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_regs", {hi, lo}, 64'h0);
    chk("arst_flags", {62'h0, busy, done}, 64'h0);
    @(negedge clk); rst = 1'b0;

    do_op("post_rst", 2'b01, 32'd3, 32'd4, 1'b0, 1'b0);
    chk("post_rst", {hi, lo}, 64'h0000_0000_0000_000C);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
